// File: rtl/conv_window_ctrl_if.sv
// Pixel-stream / window bus between the camera-side source and the
// 5x5 window scheduler. The master drives pixels in and receives windows;
// the slave (the scheduler) takes pixels and produces windows.
interface conv_window_ctrl_if;
  logic         in_valid;
  logic         in_sof;
  logic [7:0]   in_data;
  logic [199:0] pixel_data;
  logic         conv_en;
  logic         frame_done;
  logic         busy;

  modport master (
    output in_valid, in_sof, in_data,
    input  pixel_data, conv_en, frame_done, busy
  );

  modport slave (
    input  in_valid, in_sof, in_data,
    output pixel_data, conv_en, frame_done, busy
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// 5x5 window scheduler for the Gaussian convolution datapath.
// Holds the previous four image lines in line buffers, assembles a 5x5
// window per accepted pixel and flags windows that lie fully in the frame.
module conv_window_ctrl #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int COL_W      = 10,
  parameter int ROW_W      = 9
) (
  input  logic              clk,
  input  logic              rst,
  conv_window_ctrl_if.slave bus
);

  localparam int AW = $clog2(IMG_WIDTH);

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t           state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic             conv_en_reg, frame_done_reg, busy_reg;
  logic [199:0]     win_reg;

  logic             sof_pix;
  logic             accept;
  logic [COL_W-1:0] pix_col;
  logic [ROW_W-1:0] pix_row;
  logic             last_pix;
  logic             en_next;
  logic             done_next;
  logic [AW-1:0]    rd_addr;
  logic [AW-1:0]    wr_col;
  logic [31:0]      rd_bus;
  logic [31:0]      wr_bus;
  logic [39:0]      new_col;

  // A sof pixel is always treated as position (0,0), which restarts the frame.
  assign sof_pix  = bus.in_valid & bus.in_sof;
  assign pix_col  = sof_pix ? '0 : col_reg;
  assign pix_row  = sof_pix ? '0 : row_reg;
  assign last_pix = (pix_row == ROW_W'(IMG_HEIGHT - 1)) &&
                    (pix_col == COL_W'(IMG_WIDTH - 1));

  // Next-state, position advance and output strobes for the accepted pixel.
  always_comb begin
    state_next = state_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    accept     = 1'b0;
    en_next    = 1'b0;
    done_next  = 1'b0;

    case (state_reg)
      IDLE:    accept = sof_pix;
      default: accept = bus.in_valid;
    endcase

    if (accept) begin
      en_next   = (pix_row >= ROW_W'(4)) && (pix_col >= COL_W'(4));
      done_next = last_pix;
      if (last_pix) begin
        col_next   = '0;
        row_next   = '0;
        state_next = IDLE;
      end else begin
        if (pix_col == COL_W'(IMG_WIDTH - 1)) begin
          col_next = '0;
          row_next = pix_row + ROW_W'(1);
        end else begin
          col_next = pix_col + COL_W'(1);
          row_next = pix_row;
        end
        state_next = (row_next >= ROW_W'(4)) ? RUN : FILL;
      end
    end
  end

  // State, position and registered output strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      col_reg        <= '0;
      row_reg        <= '0;
      conv_en_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      col_reg        <= col_next;
      row_reg        <= row_next;
      conv_en_reg    <= en_next;
      frame_done_reg <= done_next;
      busy_reg       <= (state_next != IDLE);
    end
  end

  // The line buffers use a registered read, so the column needed by the next
  // pixel is fetched one cycle ahead. The next column never equals the one
  // being written (IMG_WIDTH >= 5), so the prefetch always sees old data.
  // An early sof pixel lands on column 0 while column c was prefetched; the
  // resulting stale data only reaches rows that are rewritten before row 4.
  assign rd_addr = rst ? '0 : col_next[AW-1:0];
  assign wr_col  = pix_col[AW-1:0];

  // Each buffer takes the old contents of the one above: L0 <- pixel,
  // L1 <- old L0, L2 <- old L1, L3 <- old L2.
  assign wr_bus = {rd_bus[23:0], bus.in_data};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lb
      logic [7:0] mem [IMG_WIDTH];
      logic [7:0] rd_q;

      // Line buffer L<gi>: write on accept, prefetch the next column.
      always_ff @(posedge clk) begin
        if (accept) begin
          mem[wr_col] <= wr_bus[gi*8 +: 8];
        end
        rd_q <= mem[rd_addr];
      end

      assign rd_bus[gi*8 +: 8] = rd_q;
    end
  endgenerate

  // New rightmost window column, top (row r-4) to bottom (row r).
  assign new_col = {bus.in_data, rd_bus[7:0], rd_bus[15:8],
                    rd_bus[23:16], rd_bus[31:24]};

  // Window register: shift one column left and append the new column.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_reg <= '0;
    end else if (accept) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < 4; j++) begin
          win_reg[(i*5+j)*8 +: 8] <= win_reg[(i*5+j+1)*8 +: 8];
        end
        win_reg[(i*5+4)*8 +: 8] <= new_col[i*8 +: 8];
      end
    end
  end

  assign bus.pixel_data = win_reg;
  assign bus.conv_en    = conv_en_reg;
  assign bus.frame_done = frame_done_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed bench for conv_window_ctrl on an 8x6 frame. Pixel value is
// r*16+c (optionally XORed with a per-frame tag); every window is compared
// against values computed from its position.
module tb_conv_window_ctrl;
  localparam int W = 8;
  localparam int H = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  conv_window_ctrl_if bus ();

  conv_window_ctrl #(
    .IMG_WIDTH (W),
    .IMG_HEIGHT(H),
    .COL_W     (3),
    .ROW_W     (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int win_cnt  = 0;
  int done_cnt = 0;

  task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int r, input int c, input logic [7:0] x);
    return 8'(r * 16 + c) ^ x;
  endfunction

  function automatic logic [199:0] exp_win(input int r, input int c, input logic [7:0] x);
    logic [199:0] w;
    w = '0;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++)
        w[(i*5+j)*8 +: 8] = pv(r - 4 + i, c - 4 + j, x);
    return w;
  endfunction

  // One clock: inputs set on the falling edge, outputs sampled 1 ns after
  // the rising edge that captured them.
  task automatic drive(input logic v, input logic s, input logic [7:0] d);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sof   = s;
    bus.in_data  = d;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    win_cnt  += int'(bus.conv_en);
    done_cnt += int'(bus.frame_done);
  endtask

  task automatic pix(input int r, input int c, input logic sof, input logic [7:0] x);
    logic exp_en, exp_done;
    exp_en   = (r >= 4) && (c >= 4);
    exp_done = (r == H - 1) && (c == W - 1);
    drive(1'b1, sof, pv(r, c, x));
    $display("pixel (%0d,%0d) sof=%0b conv_en=%0b frame_done=%0b busy=%0b",
             r, c, sof, bus.conv_en, bus.frame_done, bus.busy);
    chk("conv_en", {199'd0, bus.conv_en}, {199'd0, exp_en});
    chk("frame_done", {199'd0, bus.frame_done}, {199'd0, exp_done});
    chk("busy", {199'd0, bus.busy}, {199'd0, !exp_done});
    if (exp_en) chk("window", bus.pixel_data, exp_win(r, c, x));
  endtask

  // Send a frame starting with sof at (0,0); stops before (stop_r,stop_c).
  task automatic frame(input logic [7:0] x, input bit gaps, input int stop_r, input int stop_c);
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (r == stop_r && c == stop_c) return;
        pix(r, c, (r == 0 && c == 0), x);
        if (gaps) begin
          drive(1'b0, 1'b0, 8'hEE);
          $display("gap after (%0d,%0d) conv_en=%0b frame_done=%0b",
                   r, c, bus.conv_en, bus.frame_done);
          chk("gap_conv_en", {199'd0, bus.conv_en}, 200'd0);
          chk("gap_frame_done", {199'd0, bus.frame_done}, 200'd0);
          if (r >= 4 && c >= 4) chk("gap_hold", bus.pixel_data, exp_win(r, c, x));
        end
      end
    end
  endtask

  task automatic clr_counts();
    win_cnt  = 0;
    done_cnt = 0;
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_sof   = 1'b0;
    bus.in_data  = 8'h00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("reset: pixel_data=%h conv_en=%0b frame_done=%0b busy=%0b",
             bus.pixel_data, bus.conv_en, bus.frame_done, bus.busy);
    chk("rst_pixel_data", bus.pixel_data, 200'd0);
    chk("rst_conv_en", {199'd0, bus.conv_en}, 200'd0);
    chk("rst_frame_done", {199'd0, bus.frame_done}, 200'd0);
    chk("rst_busy", {199'd0, bus.busy}, 200'd0);
    @(negedge clk);
    rst = 1'b0;

    // Non-sof pixels in IDLE are dropped.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 8'h55);
      $display("idle drop %0d busy=%0b conv_en=%0b", k, bus.busy, bus.conv_en);
      chk("idle_busy", {199'd0, bus.busy}, 200'd0);
      chk("idle_conv_en", {199'd0, bus.conv_en}, 200'd0);
    end

    // Continuous frame.
    clr_counts();
    frame(8'h00, 1'b0, -1, -1);
    chk("f1_windows", 200'(win_cnt), 200'd8);
    chk("f1_done", 200'(done_cnt), 200'd1);

    // Same frame with an idle cycle after every pixel.
    clr_counts();
    frame(8'h00, 1'b1, -1, -1);
    chk("gap_windows", 200'(win_cnt), 200'd8);
    chk("gap_done", 200'(done_cnt), 200'd1);

    // Early sof at (3,5) aborts, then a full frame.
    clr_counts();
    frame(8'h00, 1'b0, 3, 5);
    frame(8'h00, 1'b0, -1, -1);
    chk("abort_windows", 200'(win_cnt), 200'd8);
    chk("abort_done", 200'(done_cnt), 200'd1);

    // Reset asserted together with pixel (5,2).
    clr_counts();
    frame(8'h00, 1'b0, 5, 2);
    @(negedge clk);
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sof   = 1'b0;
    bus.in_data  = pv(5, 2, 8'h00);
    @(posedge clk);
    #1;
    $display("mid-frame reset: pixel_data=%h conv_en=%0b busy=%0b",
             bus.pixel_data, bus.conv_en, bus.busy);
    chk("mrst_conv_en", {199'd0, bus.conv_en}, 200'd0);
    chk("mrst_busy", {199'd0, bus.busy}, 200'd0);
    chk("mrst_frame_done", {199'd0, bus.frame_done}, 200'd0);
    chk("mrst_pixel_data", bus.pixel_data, 200'd0);
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    clr_counts();
    frame(8'h00, 1'b0, -1, -1);
    chk("mrst_windows", 200'(win_cnt), 200'd8);
    chk("mrst_done", 200'(done_cnt), 200'd1);

    // Back-to-back frames; frame 2 data is tagged so any frame-1 leak shows.
    clr_counts();
    frame(8'h00, 1'b0, -1, -1);
    frame(8'h80, 1'b0, -1, -1);
    chk("b2b_windows", 200'(win_cnt), 200'd16);
    chk("b2b_done", 200'(done_cnt), 200'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_window_ctrl.md
Name: conv_window_ctrl

Overview:
- Streaming scheduler that sequences the 5x5 Gaussian convolution datapath.
- Accepts a raster pixel stream and holds the previous 4 image lines in internal line buffers.
- Assembles the 200-bit 5x5 window and issues `conv_en` only for windows lying fully inside the frame.
- Tracks frame position (start/end of frame) and sits between the camera-side pixel stream and the convolution block.

Parameters:
- IMG_WIDTH, 640, pixels per line (>=5)
- IMG_HEIGHT, 480, lines per frame (>=5)
- COL_W, 10, column counter width (>= clog2(IMG_WIDTH))
- ROW_W, 9, row counter width (>= clog2(IMG_HEIGHT))

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  in_data is a valid pixel this cycle
- in_sof  in  1  start of frame; qualified by in_valid; marks pixel (0,0)
- in_data  in  8  grey pixel
- pixel_data  out  200  5x5 window to convolution
- conv_en  out  1  window valid; one cycle per window
- frame_done  out  1  one-cycle pulse after last pixel of frame
- busy  out  1  high while in FILL or RUN

Behaviour:
- One clock `clk`; reset `rst` is synchronous, active-high.
- Reset: state=IDLE; row=0, col=0; pixel_data=0, conv_en=0, frame_done=0, busy=0.
- Line buffer contents are not reset; they are fully rewritten before use.
- States:
  - IDLE: waits for in_valid&in_sof. Pixels with in_valid&!in_sof are dropped.
  - FILL: rows 0..3.
  - RUN: rows 4..IMG_HEIGHT-1.
- Accepted pixel = in_valid high while in FILL/RUN, or the sof pixel in IDLE.
  - The sof pixel is pixel (0,0): it is processed and sets state=FILL.
- Per accepted pixel at (r,c):
  - Read column c of line buffers L0..L3 (L0 = row r-1 … L3 = row r-4), using read-before-write semantics.
  - Write in_data→L0[c], old L0[c]→L1[c], old L1[c]→L2[c], old L2[c]→L3[c].
  - Window register shifts one column left; new rightmost column, top to bottom, is {L3[c], L2[c], L1[c], L0[c], in_data}.
  - Advance c; on c=IMG_WIDTH-1, set c=0 and r=r+1. r=4 moves FILL→RUN.
- No accepted pixel: window, counters and line buffers hold. conv_en=0, frame_done=0.
- Packing: pixel_data[(i*5+j)*8 +: 8] = pixel at row r-4+i, col c-4+j, for i,j in 0..4.
  - Byte 0 is the oldest (top-left); byte 24 is the newest (bottom-right).
- conv_en latency: registered; high in the cycle after accepting pixel (r,c) with r>=4 and c>=4.
  - pixel_data is valid in that same cycle.
  - Window centre = (r-2, c-2).
- Columns c<4 span the line wrap, so conv_en is suppressed there.
- Windows per frame: exactly (IMG_WIDTH-4)*(IMG_HEIGHT-4).
- Last pixel (IMG_HEIGHT-1, IMG_WIDTH-1):
  - Next cycle: conv_en=1 (final window) and frame_done=1 simultaneously.
  - State→IDLE; r,c→0.
- in_sof with in_valid while in FILL/RUN (early sof): aborts the current frame.
  - The pixel is treated as (0,0); state=FILL.
  - No frame_done for the aborted frame.
  - conv_en is not asserted until row 4 of the new frame.
- rst mid-frame: next cycle outputs are at reset values and state=IDLE, regardless of in_valid/in_sof in the reset cycle.
- busy=1 in FILL/RUN (registered, follows the state).
- No backpressure: the convolution block is fully pipelined and accepts a window every cycle.

Test Plan:
All scenarios use IMG_WIDTH=8, IMG_HEIGHT=6; pixel value = r*16+c.
- Continuous frame with sof on (0,0) → conv_en pulses 8 times.
  - First pulse the cycle after (4,4): pixel_data[7:0]=0x00, [199:192]=0x44, [103:96]=0x22.
  - Last pulse window bytes: 0x13 … 0x57.
  - frame_done coincides with the last pulse.
- Same frame with in_valid low on every other cycle → identical 8 windows and values; conv_en never on an idle cycle; counters hold during gaps.
- Pixels with in_valid=1, in_sof=0 in IDLE → no state change, busy=0, no conv_en; a following sof pixel starts the frame normally.
- Early sof at pixel (3,5), then a full frame → no conv_en before the new (4,4); exactly 8 windows after; one frame_done.
- rst asserted at pixel (5,2) → next cycle conv_en=0, busy=0, pixel_data=0; a subsequent full frame gives the correct 8 windows.
- Two back-to-back frames, sof immediately after the last pixel → frame_done for frame 1, 16 total conv_en pulses; frame 2 windows contain no frame-1 data.
